// File: rtl/pc_fetch_ctrl_32.sv
// Fetch sequencer for the 32-bit MIPS PC datapath: owns the PC, runs a req/ack
// instruction fetch, holds each instruction for one execute slot and computes next-PC.
module pc_fetch_ctrl_32 #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter int unsigned TIMEOUT    = 15,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             stall,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_rdata,
   input  logic             branch,
   input  logic             zero,
   input  logic             jump,
   output logic [31:0]      instr,
   output logic             instr_valid,
   output logic [31:0]      pc,
   output logic             fetch_err,
   output logic [CNT_W-1:0] retired_count
);

   localparam int unsigned TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_ERR   = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       instr_q, instr_d;
   logic [CNT_W-1:0]  ret_q, ret_d;
   logic [TO_W-1:0]   to_q, to_d;
   logic              req_q, valid_q, err_q;

   logic [31:0]       pc4;
   logic [31:0]       br_off;
   logic [31:0]       jmp_tgt;

   assign pc4     = pc_q + 32'd4;
   assign br_off  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
   assign jmp_tgt = {pc4[31:28], instr_q[25:0], 2'b00};

   // State and datapath registers; output flags are registered decodes of the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_ADDR;
         instr_q <= 32'd0;
         ret_q   <= '0;
         to_q    <= '0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ret_q   <= ret_d;
         to_q    <= to_d;
         req_q   <= (state_d == S_FETCH);
         valid_q <= (state_d == S_EXEC);
         err_q   <= (state_d == S_ERR);
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      ret_d   = ret_q;
      to_d    = to_q;
      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            // An ack on the final allowed cycle still wins over the timeout.
            if (imem_ack) begin
               instr_d = imem_rdata;
               to_d    = '0;
               state_d = S_EXEC;
            end else if ((TIMEOUT != 0) && (to_q == TO_LAST)) begin
               to_d    = '0;
               state_d = S_ERR;
            end else begin
               to_d    = to_q + TO_W'(1);
            end
         end
         S_EXEC: begin
            if (!stall) begin
               if (jump)                pc_d = jmp_tgt;
               else if (branch && zero) pc_d = pc4 + br_off;
               else                     pc_d = pc4;
               ret_d   = ret_q + CNT_W'(1);
               state_d = run ? S_FETCH : S_IDLE;
            end
         end
         S_ERR: begin
            state_d = S_ERR;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign imem_req      = req_q;
   assign imem_addr     = pc_q;
   assign pc            = pc_q;
   assign instr         = instr_q;
   assign instr_valid   = valid_q;
   assign fetch_err     = err_q;
   assign retired_count = ret_q;

endmodule

// File: tb/tb_pc_fetch_ctrl_32.sv
// Directed bench for pc_fetch_ctrl_32: sequential fetch, branch/jump next-PC,
// stall hold, fetch timeout, reset during fetch and PC wrap.
module tb_pc_fetch_ctrl_32;

   logic        clk = 1'b0;
   logic        reset, run, stall, imem_ack, branch, zero, jump;
   logic [31:0] imem_rdata;

   logic        req_a, valid_a, err_a;
   logic [31:0] addr_a, instr_a, pc_a, ret_a;
   logic        req_b, valid_b, err_b;
   logic [31:0] addr_b, instr_b, pc_b, ret_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_fetch_ctrl_32 dut (
      .clk(clk), .reset(reset), .run(run), .stall(stall),
      .imem_req(req_a), .imem_addr(addr_a), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .branch(branch), .zero(zero), .jump(jump),
      .instr(instr_a), .instr_valid(valid_a), .pc(pc_a),
      .fetch_err(err_a), .retired_count(ret_a)
   );

   // Same stimulus, reset address near the top of the space to observe wrap.
   pc_fetch_ctrl_32 #(.RESET_ADDR(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .reset(reset), .run(run), .stall(stall),
      .imem_req(req_b), .imem_addr(addr_b), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .branch(branch), .zero(zero), .jump(jump),
      .instr(instr_b), .instr_valid(valid_b), .pc(pc_b),
      .fetch_err(err_b), .retired_count(ret_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // From FETCH: ack one instruction, execute it with the given decode, land back in FETCH.
   task automatic do_instr(input logic [31:0] word, input logic br, input logic z, input logic j);
      imem_ack = 1'b1; imem_rdata = word;
      tick();
      imem_ack = 1'b0;
      branch = br; zero = z; jump = j;
      tick();
      branch = 1'b0; zero = 1'b0; jump = 1'b0;
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; stall = 1'b0; imem_ack = 1'b0;
      branch = 1'b0; zero = 1'b0; jump = 1'b0; imem_rdata = 32'd0;
      tick(); tick();
      reset = 1'b0;
      check("rst_pc", pc_a, 32'h0);
      check("rst_instr", instr_a, 32'h0);
      check("rst_valid", {31'd0, valid_a}, 32'd0);
      check("rst_req", {31'd0, req_a}, 32'd0);
      check("rst_err", {31'd0, err_a}, 32'd0);
      check("rst_ret", ret_a, 32'd0);
      check("rst_pc_wrapinst", pc_b, 32'hFFFF_FFFC);

      // Sequential fetch
      tick();
      check("idle_hold_req", {31'd0, req_a}, 32'd0);
      run = 1'b1;
      tick();
      check("f0_req", {31'd0, req_a}, 32'd1);
      check("f0_addr", addr_a, 32'h0);
      imem_ack = 1'b1; imem_rdata = 32'h2000_0001;
      tick();
      imem_ack = 1'b0;
      check("e0_valid", {31'd0, valid_a}, 32'd1);
      check("e0_req", {31'd0, req_a}, 32'd0);
      check("e0_instr", instr_a, 32'h2000_0001);
      tick();
      check("f1_valid", {31'd0, valid_a}, 32'd0);
      check("f1_addr", addr_a, 32'h4);
      check("f1_ret", ret_a, 32'd1);
      check("wrap_pc", pc_b, 32'h0);
      check("wrap_err", {31'd0, err_b}, 32'd0);
      do_instr(32'h2000_0002, 1'b0, 1'b0, 1'b0);
      check("f2_addr", addr_a, 32'h8);
      check("f2_ret", ret_a, 32'd2);

      // Branch taken and not taken from pc 0x10
      do_instr(32'h0, 1'b0, 1'b0, 1'b0);
      do_instr(32'h0, 1'b0, 1'b0, 1'b0);
      check("pre_br_pc", pc_a, 32'h10);
      do_instr(32'h1000_FFFC, 1'b1, 1'b1, 1'b0);
      check("br_taken_pc", pc_a, 32'h4);
      do_instr(32'h0, 1'b0, 1'b0, 1'b0);
      do_instr(32'h0, 1'b0, 1'b0, 1'b0);
      do_instr(32'h0, 1'b0, 1'b0, 1'b0);
      check("pre_br2_pc", pc_a, 32'h10);
      do_instr(32'h1000_FFFC, 1'b1, 1'b0, 1'b0);
      check("br_nottaken_pc", pc_a, 32'h14);

      // Jump into the 0x1 region, then jump with branch also asserted
      do_instr(32'h0BFF_FFFF, 1'b0, 1'b0, 1'b1);
      check("jmp_pc", pc_a, 32'h0FFF_FFFC);
      do_instr(32'h0, 1'b0, 1'b0, 1'b0);
      check("seq_region_pc", pc_a, 32'h1000_0000);
      do_instr(32'h0800_0040, 1'b1, 1'b1, 1'b1);
      check("jmp_prio_pc", pc_a, 32'h1000_0100);
      check("ret_12", ret_a, 32'd12);

      // Stall holds EXEC
      imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
      tick();
      imem_ack = 1'b0; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_valid", {31'd0, valid_a}, 32'd1);
         check("stall_pc", pc_a, 32'h1000_0100);
         check("stall_instr", instr_a, 32'h1234_5678);
         check("stall_ret", ret_a, 32'd12);
      end
      stall = 1'b0;
      tick();
      check("unstall_pc", pc_a, 32'h1000_0104);
      check("unstall_ret", ret_a, 32'd13);
      check("unstall_valid", {31'd0, valid_a}, 32'd0);

      // Timeout: 15 request cycles then sticky error
      for (int i = 0; i < 15; i++) begin
         check("to_req_high", {31'd0, req_a}, 32'd1);
         check("to_no_err", {31'd0, err_a}, 32'd0);
         tick();
      end
      check("to_req_low", {31'd0, req_a}, 32'd0);
      check("to_err", {31'd0, err_a}, 32'd1);
      check("to_valid", {31'd0, valid_a}, 32'd0);
      imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555;
      tick(); tick();
      imem_ack = 1'b0;
      check("err_sticky", {31'd0, err_a}, 32'd1);
      check("err_req", {31'd0, req_a}, 32'd0);
      check("err_valid", {31'd0, valid_a}, 32'd0);

      // Reset clears error; ack on the 15th FETCH cycle is accepted
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst2_err", {31'd0, err_a}, 32'd0);
      check("rst2_pc", pc_a, 32'h0);
      tick();
      for (int i = 0; i < 14; i++) tick();
      check("ack15_req", {31'd0, req_a}, 32'd1);
      imem_ack = 1'b1; imem_rdata = 32'hCAFE_0015;
      tick();
      imem_ack = 1'b0;
      check("ack15_valid", {31'd0, valid_a}, 32'd1);
      check("ack15_err", {31'd0, err_a}, 32'd0);
      check("ack15_instr", instr_a, 32'hCAFE_0015);
      tick();
      check("ack15_next_pc", pc_a, 32'h4);

      // Reset together with ack mid-fetch
      reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      reset = 1'b0; imem_ack = 1'b0; run = 1'b0;
      check("rstack_instr", instr_a, 32'h0);
      check("rstack_valid", {31'd0, valid_a}, 32'd0);
      check("rstack_req", {31'd0, req_a}, 32'd0);
      check("rstack_pc", pc_a, 32'h0);
      tick();
      check("idle_stay_req", {31'd0, req_a}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl_32.md
Name: pc_fetch_ctrl_32

Overview:
Fetch sequencer for the 32-bit MIPS PC datapath. It owns the program counter, issues instruction-memory requests with a req/ack handshake, and presents each fetched instruction for exactly one execute slot. It computes next-PC from the branch, zero and jump decode inputs. It sits between the instruction memory and the control/ALU stage, turning the single-cycle PC path into a handshaked, stallable fetch loop.

Parameters:
RESET_ADDR, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 15, max consecutive FETCH cycles without imem_ack before fetch error; 0 disables timeout
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
run  input  1  enable; allows leaving IDLE and starting new fetches
stall  input  1  holds current instruction in EXEC
imem_req  output  1  instruction-memory request
imem_addr  output  32  fetch address, always equals pc
imem_ack  input  1  memory has valid imem_rdata this cycle
imem_rdata  input  32  instruction word from memory
branch  input  1  decoded branch of current instr, sampled in EXEC
zero  input  1  ALU zero flag for current instr, sampled in EXEC
jump  input  1  decoded jump of current instr, sampled in EXEC
instr  output  32  latched instruction
instr_valid  output  1  instr is live for execute
pc  output  32  address of current/pending instruction
fetch_err  output  1  sticky memory-timeout flag
retired_count  output  CNT_W  instructions completed

Behaviour:
- Reset, synchronous: state=IDLE, pc=RESET_ADDR, instr=0, instr_valid=0, fetch_err=0, retired_count=0, timeout counter=0. Reset wins over all other inputs, including imem_ack in the same cycle and reset mid-FETCH.
- States: IDLE, FETCH, EXEC, ERR. imem_req=1 iff state==FETCH. instr_valid=1 iff state==EXEC.
- IDLE: run=1 -> FETCH next cycle; otherwise stay.
- FETCH: imem_req held high, imem_addr=pc.
  - imem_ack=1: instr<=imem_rdata, timeout counter cleared, -> EXEC.
  - No ack: counter increments.
  - TIMEOUT>0 and TIMEOUT cycles elapsed in FETCH with no ack -> ERR. An ack on the TIMEOUT-th cycle is accepted.
  - Deasserting run in FETCH does not abort the fetch.
- EXEC, stall=1: hold everything. instr_valid stays 1; pc, instr and retired_count unchanged.
- EXEC, stall=0: sample branch, zero and jump; update pc; retired_count += 1 (wraps modulo 2^CNT_W). Next state FETCH if run=1, else IDLE.
- Next-PC, with pc4 = pc+4 modulo 2^32:
  - jump=1: {pc4[31:28], instr[25:0], 2'b00}. Jump has priority over branch.
  - else branch&zero: pc4 + (sign_extend(instr[15:0]) << 2), modulo 2^32.
  - else: pc4.
- ERR: imem_req=0, fetch_err=1, instr_valid=0. Stays in ERR until reset. imem_ack is ignored.
- Minimum throughput, zero-wait memory with ack in the first FETCH cycle: one instruction per 2 cycles (FETCH, EXEC).
- pc wrap: 0xFFFF_FFFC sequential -> 0x0000_0000, no flag.

Test Plan:
- Sequential fetch: reset, run=1, ack in each FETCH cycle, branch=jump=0 -> imem_addr 0x0, 0x4, 0x8 on successive FETCHes. retired_count=2 after second EXEC. instr_valid pulses one cycle each.
- Branch: pc=0x10, instr[15:0]=0xFFFC, branch=1, zero=1 -> next pc=0x04. Same with zero=0 -> 0x14.
- Jump priority: pc=0x1000_0000, instr[25:0]=0x0000040, jump=1, branch=1, zero=1 -> next pc=0x1000_0100.
- Stall: hold stall=1 for 3 EXEC cycles -> pc, instr and retired_count frozen, instr_valid=1 throughout. Release -> pc advances by 4 and retired_count increments once.
- Timeout: TIMEOUT=15, never ack -> imem_req high for exactly 15 cycles, then fetch_err=1 and imem_req=0 persist. Separately, ack on cycle 15 -> normal EXEC, no error. Reset clears fetch_err and returns pc to RESET_ADDR.
- Reset mid-fetch and wrap: assert reset together with imem_ack in FETCH -> IDLE, instr=0, ack dropped. With RESET_ADDR=0xFFFF_FFFC, one sequential instruction -> pc=0x0000_0000.
